// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute pipeline register behind the register file, with load-use stall and
// writeback snooping of held operands. Define WB_BYPASS_EN to forward same-edge writeback on capture.
module id_ex_operand_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int PC_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_reg_write,
  output logic              out_mem_read
);

  logic              loadShadow;
  logic [REG_AW-1:0] loadShadowRd;
  logic [REG_AW-1:0] heldRs1;
  logic [REG_AW-1:0] heldRs2;

  logic              hazard;
  logic              fireIn;
  logic              fireOut;
  logic              wbHit1;
  logic              wbHit2;
  logic [XLEN-1:0]   capRs1;
  logic [XLEN-1:0]   capRs2;

  function automatic logic loadUse(input logic [REG_AW-1:0] rs);
    return (rs != '0) &&
           ((out_valid && out_mem_read && rs == out_rd) ||
            (loadShadow && rs == loadShadowRd));
  endfunction

  assign hazard   = loadUse(in_rs1) || loadUse(in_rs2);
  assign in_ready = !hazard && !flush && (!out_valid || out_ready);
  assign fireIn   = in_valid && in_ready;
  assign fireOut  = out_valid && out_ready;

  // Writeback hits on the operands currently held in the register.
  assign wbHit1 = wb_reg_write && (wb_rd != '0) && (wb_rd == heldRs1);
  assign wbHit2 = wb_reg_write && (wb_rd != '0) && (wb_rd == heldRs2);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    capRs1 = in_rs1_val;
    capRs2 = in_rs2_val;
`ifdef WB_BYPASS_EN
    // The regfile write landing on this edge is not yet visible on readData.
    if (wb_reg_write && wb_rd != '0 && wb_rd == in_rs1) capRs1 = wb_data;
    if (wb_reg_write && wb_rd != '0 && wb_rd == in_rs2) capRs2 = wb_data;
`endif
    if (in_rs1 == '0) capRs1 = '0;
    if (in_rs2 == '0) capRs2 = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_rs1_val   <= '0;
      out_rs2_val   <= '0;
      out_rd        <= '0;
      out_imm       <= '0;
      out_pc        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      heldRs1       <= '0;
      heldRs2       <= '0;
      loadShadow    <= 1'b0;
      loadShadowRd  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      loadShadow <= 1'b0;
    end else begin
      // One-cycle shadow of a departing load covers the bubble the consumer still needs.
      loadShadow   <= fireOut && out_mem_read;
      loadShadowRd <= out_rd;
      if (fireIn) begin
        out_valid     <= 1'b1;
        out_rs1_val   <= capRs1;
        out_rs2_val   <= capRs2;
        out_rd        <= in_rd;
        out_imm       <= in_imm;
        out_pc        <= in_pc;
        out_reg_write <= in_reg_write;
        out_mem_read  <= in_mem_read;
        heldRs1       <= in_rs1;
        heldRs2       <= in_rs2;
      end else if (fireOut) begin
        out_valid <= 1'b0;
      end else if (out_valid) begin
        if (wbHit1) out_rs1_val <= wb_data;
        if (wbHit2) out_rs2_val <= wb_data;
      end
    end
  end

endmodule
